irrigation_sequencer: RTL and testbench



---
 rtl/irrigation_pkg.sv | 24 ++
 rtl/phase_timer.sv | 41 ++++
 rtl/irrigation_sequencer.sv | 154 +++++++++++++++
 tb/tb_irrigation_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/irrigation_pkg.sv
// Purpose: shared types and constants for the irrigation sequencer (state encoding, request codes, timer width).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package irrigation_pkg;

    // Width of the per-phase minute counter and of every phase-length parameter.
    localparam int PHASE_W = 6;

    // Coded irrigation request coming from the mode encoder.
    localparam logic [1:0] IRG_NONE = 2'b00;
    localparam logic [1:0] IRG_SPR  = 2'b01;
    localparam logic [1:0] IRG_DRIP = 2'b10;
    localparam logic [1:0] IRG_BAD  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRIME    = 3'd1,
        ST_SPRINKLE = 3'd2,
        ST_DRIP     = 3'd3,
        ST_DRAIN    = 3'd4,
        ST_FAULT    = 3'd5
    } state_t;

endpackage

// File: rtl/phase_timer.sv
// Purpose: minute counter for one sequencer phase; flags the tick that completes the phase.
// Latency: o_expire is combinational on the terminal tick; o_count updates on the following edge.
// Backpressure: none; every i_tick pulse is consumed unless i_clear is high.
//
// Ports: i_clk/i_rst clock and async active-high reset; i_clear zeroes the count (wins over i_tick);
//        i_tick one-cycle minute pulse; i_length phase length in ticks;
//        o_count saturating tick count; o_expire high when this tick makes the count reach i_length.
module phase_timer
    import irrigation_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clear,
    input  logic               i_tick,
    input  logic [PHASE_W-1:0] i_length,
    output logic [PHASE_W-1:0] o_count,
    output logic               o_expire
);

    logic [PHASE_W-1:0] r_count;
    logic [PHASE_W:0]   w_count_inc;   // one bit wider so the compare cannot wrap at 63

    assign w_count_inc = {1'b0, r_count} + (PHASE_W+1)'(1);

    // Expire deliberately ignores i_clear: the FSM derives i_clear from its next state,
    // which itself depends on o_expire.
    assign o_expire = i_tick && (w_count_inc == {1'b0, i_length});

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_tick && !(&r_count)) begin
            r_count <= w_count_inc[PHASE_W-1:0];
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/irrigation_sequencer.sv
// Purpose: timed pump/valve sequencer (prime, sprinkle or drip, drain) with latched fault shutdown.
// Latency: 1 cycle from sampled request/alarm to registered actuator outputs.
// Backpressure: none; requests are sampled only in IDLE (and drip handover in SPRINKLE), otherwise ignored.
//
// Ports: i_clk, i_rst (async active-high); i_tick_min minute pulse; i_coded_irg request code;
//        i_alarm, i_water_low fault levels; i_fault_clr fault acknowledge;
//        o_pump_on, o_valve_spr, o_valve_drip actuators; o_busy, o_fault, o_done status; o_phase_min phase minutes.
module irrigation_sequencer
    import irrigation_pkg::*;
#(
    parameter int PRIME_TICKS = 2,
    parameter int SPR_TICKS   = 10,
    parameter int DRIP_TICKS  = 30,
    parameter int DRAIN_TICKS = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_tick_min,
    input  logic [1:0]         i_coded_irg,
    input  logic               i_alarm,
    input  logic               i_water_low,
    input  logic               i_fault_clr,
    output logic               o_pump_on,
    output logic               o_valve_spr,
    output logic               o_valve_drip,
    output logic               o_busy,
    output logic               o_fault,
    output logic               o_done,
    output logic [PHASE_W-1:0] o_phase_min
);

    localparam logic [PHASE_W-1:0] L_PRIME = PHASE_W'(PRIME_TICKS);
    localparam logic [PHASE_W-1:0] L_SPR   = PHASE_W'(SPR_TICKS);
    localparam logic [PHASE_W-1:0] L_DRIP  = PHASE_W'(DRIP_TICKS);
    localparam logic [PHASE_W-1:0] L_DRAIN = PHASE_W'(DRAIN_TICKS);

    state_t             r_state;
    state_t             w_next_state;
    logic [1:0]         r_mode;
    logic               r_pump_on;
    logic               r_valve_spr;
    logic               r_valve_drip;
    logic               r_busy;
    logic               r_fault;
    logic               r_done;
    logic [PHASE_W-1:0] w_length;
    logic               w_clear;
    logic               w_expire;
    logic               w_fault_cond;

    assign w_fault_cond = i_alarm || i_water_low;

    always_comb begin
        w_length = '0;
        case (r_state)
            ST_PRIME:    w_length = L_PRIME;
            ST_SPRINKLE: w_length = L_SPR;
            ST_DRIP:     w_length = L_DRIP;
            ST_DRAIN:    w_length = L_DRAIN;
            default:     w_length = '0;
        endcase
    end

    // Priority: fault condition, then fault_clr, then phase end / handover.
    always_comb begin
        w_next_state = r_state;
        if (r_state != ST_FAULT && w_fault_cond) begin
            w_next_state = ST_FAULT;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    case (i_coded_irg)
                        IRG_SPR, IRG_DRIP: w_next_state = ST_PRIME;
                        IRG_NONE, IRG_BAD: w_next_state = ST_IDLE;
                        default:           w_next_state = ST_IDLE;
                    endcase
                end
                ST_PRIME: begin
                    if (w_expire) begin
                        w_next_state = (r_mode == IRG_DRIP) ? ST_DRIP : ST_SPRINKLE;
                    end
                end
                ST_SPRINKLE: begin
                    // Handover to drip skips re-priming; 00/11 mean "keep sprinkling".
                    if (i_coded_irg == IRG_DRIP) begin
                        w_next_state = ST_DRIP;
                    end else if (w_expire) begin
                        w_next_state = ST_DRAIN;
                    end
                end
                ST_DRIP: begin
                    if (w_expire) w_next_state = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_expire) w_next_state = ST_IDLE;
                end
                ST_FAULT: begin
                    if (i_fault_clr && !w_fault_cond) w_next_state = ST_IDLE;
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // Clearing on every state change swallows a tick that coincides with a transition;
    // holding clear in IDLE/FAULT makes ticks there no-ops.
    assign w_clear = (w_next_state != r_state) || (r_state == ST_IDLE) || (r_state == ST_FAULT);

    phase_timer u_phase_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (w_clear),
        .i_tick   (i_tick_min),
        .i_length (w_length),
        .o_count  (o_phase_min),
        .o_expire (w_expire)
    );

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_mode       <= IRG_NONE;
            r_pump_on    <= 1'b0;
            r_valve_spr  <= 1'b0;
            r_valve_drip <= 1'b0;
            r_busy       <= 1'b0;
            r_fault      <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_IDLE && w_next_state == ST_PRIME) begin
                r_mode <= i_coded_irg;
            end else if (r_state == ST_SPRINKLE && w_next_state == ST_DRIP) begin
                r_mode <= IRG_DRIP;
            end
            r_pump_on    <= (w_next_state == ST_PRIME) || (w_next_state == ST_SPRINKLE) ||
                            (w_next_state == ST_DRIP);
            r_valve_spr  <= (w_next_state == ST_SPRINKLE);
            r_valve_drip <= (w_next_state == ST_DRIP);
            r_busy       <= (w_next_state != ST_IDLE) && (w_next_state != ST_FAULT);
            r_fault      <= (w_next_state == ST_FAULT);
            r_done       <= (r_state == ST_DRAIN) && (w_next_state == ST_IDLE);
        end
    end

    assign o_pump_on    = r_pump_on;
    assign o_valve_spr  = r_valve_spr;
    assign o_valve_drip = r_valve_drip;
    assign o_busy       = r_busy;
    assign o_fault      = r_fault;
    assign o_done       = r_done;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Purpose: directed self-checking bench for irrigation_sequencer with default parameters.
// Latency: inputs driven and outputs sampled 1 ns after each rising clock edge.
// Backpressure: n/a.
module tb_irrigation_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [1:0] irg = 2'b00;
    logic       alarm = 1'b0;
    logic       wlow = 1'b0;
    logic       fclr = 1'b0;
    logic       pump, spr, drip, busy, fault, done;
    logic [5:0] phase;
    logic [5:0] obs;   // {pump, spr, drip, busy, fault, done}

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int excl_cnt = 0;
    int d0;

    irrigation_sequencer dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_tick_min   (tick),
        .i_coded_irg  (irg),
        .i_alarm      (alarm),
        .i_water_low  (wlow),
        .i_fault_clr  (fclr),
        .o_pump_on    (pump),
        .o_valve_spr  (spr),
        .o_valve_drip (drip),
        .o_busy       (busy),
        .o_fault      (fault),
        .o_done       (done),
        .o_phase_min  (phase)
    );

    assign obs = {pump, spr, drip, busy, fault, done};

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (spr && drip) excl_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // n minute ticks, one every 8 cycles; returns 7 cycles after the last tick edge.
    task automatic run_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            repeat (7) step();
        end
    endtask

    task automatic test_reset();
        irg = 2'b01;
        tick = 1'b1;
        step();
        step();
        n_cmp++; if (obs !== 6'b000000) begin n_err++; $display("FAIL reset_outs: got %b want %b", obs, 6'b000000); end
        n_cmp++; if (phase !== 6'd0) begin n_err++; $display("FAIL reset_phase: got %0d want %0d", phase, 0); end
        irg = 2'b00;
        tick = 1'b0;
        rst = 1'b0;
        step();
        n_cmp++; if (obs !== 6'b000000) begin n_err++; $display("FAIL post_reset_outs: got %b want %b", obs, 6'b000000); end
    endtask

    task automatic test_sprinkle();
        irg = 2'b01;
        step();
        n_cmp++; if (obs !== 6'b100100) begin n_err++; $display("FAIL spr_prime_entry: got %b want %b", obs, 6'b100100); end
        run_ticks(1);
        n_cmp++; if (obs !== 6'b100100) begin n_err++; $display("FAIL spr_prime_1: got %b want %b", obs, 6'b100100); end
        n_cmp++; if (phase !== 6'd1) begin n_err++; $display("FAIL spr_prime_phase: got %0d want %0d", phase, 1); end
        run_ticks(1);
        n_cmp++; if (obs !== 6'b110100) begin n_err++; $display("FAIL spr_entry: got %b want %b", obs, 6'b110100); end
        n_cmp++; if (phase !== 6'd0) begin n_err++; $display("FAIL spr_entry_phase: got %0d want %0d", phase, 0); end
        run_ticks(9);
        n_cmp++; if (obs !== 6'b110100) begin n_err++; $display("FAIL spr_9: got %b want %b", obs, 6'b110100); end
        n_cmp++; if (phase !== 6'd9) begin n_err++; $display("FAIL spr_9_phase: got %0d want %0d", phase, 9); end
        run_ticks(1);
        n_cmp++; if (obs !== 6'b000100) begin n_err++; $display("FAIL spr_drain: got %b want %b", obs, 6'b000100); end
        d0 = done_cnt;
        tick = 1'b1;
        step();
        tick = 1'b0;
        n_cmp++; if (obs !== 6'b000001) begin n_err++; $display("FAIL spr_done: got %b want %b", obs, 6'b000001); end
        irg = 2'b00;
        step();
        n_cmp++; if (obs !== 6'b000000) begin n_err++; $display("FAIL spr_idle: got %b want %b", obs, 6'b000000); end
        n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL spr_done_count: got %0d want %0d", done_cnt - d0, 1); end
    endtask

    task automatic test_drip();
        irg = 2'b10;
        step();
        n_cmp++; if (obs !== 6'b100100) begin n_err++; $display("FAIL drip_prime: got %b want %b", obs, 6'b100100); end
        irg = 2'b00;
        run_ticks(2);
        n_cmp++; if (obs !== 6'b101100) begin n_err++; $display("FAIL drip_entry: got %b want %b", obs, 6'b101100); end
        run_ticks(29);
        n_cmp++; if (obs !== 6'b101100) begin n_err++; $display("FAIL drip_29: got %b want %b", obs, 6'b101100); end
        n_cmp++; if (phase !== 6'd29) begin n_err++; $display("FAIL drip_29_phase: got %0d want %0d", phase, 29); end
        run_ticks(1);
        n_cmp++; if (obs !== 6'b000100) begin n_err++; $display("FAIL drip_drain: got %b want %b", obs, 6'b000100); end
        tick = 1'b1;
        step();
        tick = 1'b0;
        n_cmp++; if (obs !== 6'b000001) begin n_err++; $display("FAIL drip_done: got %b want %b", obs, 6'b000001); end
        step();
        n_cmp++; if (obs !== 6'b000000) begin n_err++; $display("FAIL drip_idle: got %b want %b", obs, 6'b000000); end
    endtask

    task automatic test_handover();
        irg = 2'b01;
        step();
        run_ticks(2);
        run_ticks(4);
        n_cmp++; if (obs !== 6'b110100) begin n_err++; $display("FAIL ho_spr: got %b want %b", obs, 6'b110100); end
        n_cmp++; if (phase !== 6'd4) begin n_err++; $display("FAIL ho_spr_phase: got %0d want %0d", phase, 4); end
        irg = 2'b10;
        step();
        n_cmp++; if (obs !== 6'b101100) begin n_err++; $display("FAIL ho_switch: got %b want %b", obs, 6'b101100); end
        n_cmp++; if (phase !== 6'd0) begin n_err++; $display("FAIL ho_switch_phase: got %0d want %0d", phase, 0); end
        irg = 2'b00;
        run_ticks(29);
        n_cmp++; if (obs !== 6'b101100) begin n_err++; $display("FAIL ho_drip_29: got %b want %b", obs, 6'b101100); end
        run_ticks(1);
        n_cmp++; if (obs !== 6'b000100) begin n_err++; $display("FAIL ho_drain: got %b want %b", obs, 6'b000100); end
        tick = 1'b1;
        step();
        tick = 1'b0;
        n_cmp++; if (obs !== 6'b000001) begin n_err++; $display("FAIL ho_done: got %b want %b", obs, 6'b000001); end
        step();
        n_cmp++; if (excl_cnt !== 0) begin n_err++; $display("FAIL valve_exclusive: got %0d overlaps want %0d", excl_cnt, 0); end
    endtask

    task automatic test_fault();
        irg = 2'b10;
        step();
        irg = 2'b00;
        run_ticks(2);
        run_ticks(11);
        n_cmp++; if (phase !== 6'd11) begin n_err++; $display("FAIL flt_drip_phase: got %0d want %0d", phase, 11); end
        d0 = done_cnt;
        alarm = 1'b1;
        tick = 1'b1;
        step();
        tick = 1'b0;
        n_cmp++; if (obs !== 6'b000010) begin n_err++; $display("FAIL flt_enter: got %b want %b", obs, 6'b000010); end
        n_cmp++; if (phase !== 6'd0) begin n_err++; $display("FAIL flt_phase: got %0d want %0d", phase, 0); end
        fclr = 1'b1;
        step();
        fclr = 1'b0;
        n_cmp++; if (obs !== 6'b000010) begin n_err++; $display("FAIL flt_clr_ignored: got %b want %b", obs, 6'b000010); end
        alarm = 1'b0;
        step();
        n_cmp++; if (obs !== 6'b000010) begin n_err++; $display("FAIL flt_latched: got %b want %b", obs, 6'b000010); end
        fclr = 1'b1;
        step();
        fclr = 1'b0;
        n_cmp++; if (obs !== 6'b000000) begin n_err++; $display("FAIL flt_cleared: got %b want %b", obs, 6'b000000); end
        n_cmp++; if (done_cnt !== d0) begin n_err++; $display("FAIL flt_no_done: got %0d want %0d", done_cnt, d0); end
        wlow = 1'b1;
        step();
        n_cmp++; if (obs !== 6'b000010) begin n_err++; $display("FAIL wlow_idle: got %b want %b", obs, 6'b000010); end
        fclr = 1'b1;
        step();
        n_cmp++; if (obs !== 6'b000010) begin n_err++; $display("FAIL wlow_clr_ignored: got %b want %b", obs, 6'b000010); end
        wlow = 1'b0;
        step();
        fclr = 1'b0;
        n_cmp++; if (obs !== 6'b000000) begin n_err++; $display("FAIL wlow_cleared: got %b want %b", obs, 6'b000000); end
    endtask

    task automatic test_boundaries();
        irg = 2'b11;
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        step();
        n_cmp++; if (obs !== 6'b000000) begin n_err++; $display("FAIL bad_req_idle: got %b want %b", obs, 6'b000000); end
        n_cmp++; if (phase !== 6'd0) begin n_err++; $display("FAIL idle_tick_phase: got %0d want %0d", phase, 0); end
        // Back-to-back ticks: the second ends PRIME and must not count in SPRINKLE.
        irg = 2'b01;
        step();
        irg = 2'b00;
        tick = 1'b1;
        step();
        step();
        n_cmp++; if (obs !== 6'b110100) begin n_err++; $display("FAIL tick_entry_state: got %b want %b", obs, 6'b110100); end
        n_cmp++; if (phase !== 6'd0) begin n_err++; $display("FAIL tick_entry_phase: got %0d want %0d", phase, 0); end
        step();
        tick = 1'b0;
        n_cmp++; if (phase !== 6'd1) begin n_err++; $display("FAIL tick_after_entry: got %0d want %0d", phase, 1); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (obs !== 6'b000000) begin n_err++; $display("FAIL rst_mid_spr: got %b want %b", obs, 6'b000000); end
        step();
        rst = 1'b0;
        irg = 2'b01;
        step();
        irg = 2'b00;
        step();
        n_cmp++; if (obs !== 6'b100100) begin n_err++; $display("FAIL rst_prime_on: got %b want %b", obs, 6'b100100); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (obs !== 6'b000000) begin n_err++; $display("FAIL rst_mid_prime: got %b want %b", obs, 6'b000000); end
        n_cmp++; if (phase !== 6'd0) begin n_err++; $display("FAIL rst_mid_prime_phase: got %0d want %0d", phase, 0); end
        step();
        rst = 1'b0;
        step();
        n_cmp++; if (obs !== 6'b000000) begin n_err++; $display("FAIL rst_release: got %b want %b", obs, 6'b000000); end
    endtask

    initial begin
        test_reset();
        test_sprinkle();
        test_drip();
        test_handover();
        test_fault();
        test_boundaries();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
